spi_tx_sched: RTL and testbench

- Frame scheduler in front of the SPI slave TX/RX buffers.
- Holds one pending word per data channel.
- Arbitrates which channel's word is presented as the next SPI TX frame, using the command received in the previous frame or round-robin.
- Retires a word only once the slave reports the word was captured.
- Runs entirely in the i_clk domain; i_ssel_n is synchronized internally.

---
 rtl/spi_tx_sched.sv | 145 ++++++++++++++
 tb/tb_spi_tx_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sched.sv
// SPI TX frame scheduler: one holding register per producer channel, picks the
// next frame's word by forced channel or round-robin, retires it on slave capture.
module spi_tx_sched #(
  parameter int                 DATA_W     = 16,
  parameter int                 CMD_W      = 2,
  parameter logic [DATA_W-1:0]  EMPTY_WORD = {DATA_W{1'b1}},
  localparam int                N_CH       = 2**CMD_W - 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_CH*DATA_W-1:0] i_ch_data,
  input  logic [N_CH-1:0]        i_ch_valid,
  output logic [N_CH-1:0]        o_ch_ack,
  input  logic                   i_ssel_n,
  input  logic                   i_data_capt_st,
  input  logic [CMD_W-1:0]       i_rx_cmd,
  output logic [DATA_W-1:0]      o_tx_buff,
  output logic [CMD_W-1:0]       o_tx_ch,
  output logic [7:0]             o_frame_cnt,
  output logic [7:0]             o_abort_cnt
);

  // Handshake: producer k holds i_ch_valid[k] with stable data; the word is
  // taken on the rising i_clk edge where o_ch_ack[k] is high, after which the
  // producer drops valid or presents its next word.
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_XFER, S_END} state_t;

  state_t               state;
  logic [1:0]           ssel_sync;
  logic                 ssel_s;
  logic                 capt_q;
  logic                 capt_rise;
  logic [CMD_W-1:0]     mode;
  logic [CMD_W-1:0]     rr_ptr;
  logic [DATA_W-1:0]    hold_data [N_CH];
  logic [N_CH-1:0]      hold_full;
  logic [N_CH-1:0]      consume;
  logic [N_CH-1:0]      load;
  logic [DATA_W-1:0]    sel_word;
  logic [CMD_W-1:0]     sel_ch;
  logic                 found;
  logic [CMD_W-1:0]     idx;

  assign ssel_s    = ssel_sync[1];
  assign capt_rise = i_data_capt_st & ~capt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ssel_sync <= 2'b11;
      capt_q    <= 1'b0;
    end else begin
      ssel_sync <= {ssel_sync[0], i_ssel_n};
      capt_q    <= i_data_capt_st;
    end
  end

  always_comb begin
    consume = '0;
    if (state == S_HOLD && capt_rise && o_tx_ch != '0)
      consume[o_tx_ch - 1'b1] = 1'b1;
  end

  // A register being retired this cycle may accept its next word in the same cycle.
  assign load     = i_ch_valid & (~hold_full | consume);
  assign o_ch_ack = load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_full <= '0;
      for (int k = 0; k < N_CH; k++) hold_data[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (load[k]) begin
          hold_data[k] <= i_ch_data[k*DATA_W +: DATA_W];
          hold_full[k] <= 1'b1;
        end else if (consume[k]) begin
          hold_full[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel_word = EMPTY_WORD;
    sel_ch   = '0;
    found    = 1'b0;
    idx      = '0;
    if (mode != '0) begin
      if (hold_full[mode - 1'b1]) begin
        sel_word = hold_data[mode - 1'b1];
        sel_ch   = mode;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        idx = CMD_W'((int'(rr_ptr) + i) % N_CH);
        if (!found && hold_full[idx]) begin
          found    = 1'b1;
          sel_word = hold_data[idx];
          sel_ch   = idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_tx_buff   <= EMPTY_WORD;
      o_tx_ch     <= '0;
      o_frame_cnt <= '0;
      o_abort_cnt <= '0;
      mode        <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_tx_buff <= sel_word;
          o_tx_ch   <= sel_ch;
          if (!ssel_s) state <= S_HOLD;
        end
        S_HOLD: begin
          if (capt_rise) begin
            state <= S_XFER;
          end else if (ssel_s) begin
            state <= S_IDLE;
            if (o_abort_cnt != 8'hFF) o_abort_cnt <= o_abort_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (ssel_s) state <= S_END;
        end
        S_END: begin
          // Channels fill the whole command space, so every code decodes to a mode.
          mode <= i_rx_cmd;
          if (o_tx_ch != '0)
            rr_ptr <= (o_tx_ch == CMD_W'(N_CH)) ? '0 : o_tx_ch;
          o_frame_cnt <= o_frame_cnt + 8'd1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Bench for spi_tx_sched: directed frame scenarios plus random frames checked
// against a channel/mode/pointer model of the scheduling rules.
module tb_spi_tx_sched;

  localparam int DW = 16;
  localparam int NC = 3;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [NC*DW-1:0] ch_data;
  logic [NC-1:0]  ch_valid;
  logic [NC-1:0]  ch_ack;
  logic           ssel_n;
  logic           capt;
  logic [1:0]     rx_cmd;
  logic [DW-1:0]  tx_buff;
  logic [1:0]     tx_ch;
  logic [7:0]     frame_cnt;
  logic [7:0]     abort_cnt;

  spi_tx_sched dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ch_data(ch_data), .i_ch_valid(ch_valid), .o_ch_ack(ch_ack),
    .i_ssel_n(ssel_n), .i_data_capt_st(capt), .i_rx_cmd(rx_cmd),
    .o_tx_buff(tx_buff), .o_tx_ch(tx_ch),
    .o_frame_cnt(frame_cnt), .o_abort_cnt(abort_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [DW-1:0] m_data [NC];
  logic          m_full [NC];
  int            m_mode, m_rr, m_frames, m_aborts, exp_acks, ack_pulses;
  logic [DW-1:0] cur_w;
  logic [1:0]    cur_c;
  logic [DW-1:0] exp_w;
  logic [1:0]    exp_c;

  always @(posedge i_clk) if (|ch_ack) ack_pulses <= ack_pulses + $countones(ch_ack);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
    end
    m_mode = 0; m_rr = 0; m_frames = 0; m_aborts = 0;
  endtask

  // Forced channel if one is set, otherwise first full channel from the pointer.
  task automatic predict(output logic [DW-1:0] w, output logic [1:0] c);
    w = 16'hFFFF;
    c = 2'd0;
    if (m_mode != 0) begin
      if (m_full[m_mode-1]) begin
        w = m_data[m_mode-1];
        c = 2'(m_mode);
      end
    end else begin
      for (int i = NC - 1; i >= 0; i--) begin
        int j;
        j = (m_rr + i) % NC;
        if (m_full[j]) begin
          w = m_data[j];
          c = 2'(j + 1);
        end
      end
    end
  endtask

  task automatic load_word(input int ch, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    ch_data[ch*DW +: DW] = d;
    ch_valid[ch] = 1'b1;
    #1;
    for (int t = 0; t < 20; t++) begin
      if (ch_ack[ch]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    ch_valid[ch] = 1'b0;
    check("load_ack", 32'(ok), 32'd1);
    m_data[ch] = d;
    m_full[ch] = 1'b1;
    exp_acks++;
  endtask

  task automatic frame_open();
    predict(exp_w, exp_c);
    step(3);
    ssel_n = 1'b0;
    step(4);
    cur_w = tx_buff;
    cur_c = tx_ch;
    check("open_word", 32'(tx_buff), 32'(exp_w));
    check("open_ch", 32'(tx_ch), 32'(exp_c));
  endtask

  task automatic frame_close(input int cmd);
    capt = 1'b1;
    step(2);
    capt = 1'b0;
    check("buff_stable", 32'(tx_buff), 32'(exp_w));
    rx_cmd = 2'(cmd);
    ssel_n = 1'b1;
    step(5);
    if (exp_c != 0) begin
      m_full[exp_c-1] = 1'b0;
      m_rr = exp_c % NC;
    end
    m_mode = cmd;
    m_frames++;
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
    check("abort_cnt_keep", 32'(abort_cnt), 32'(m_aborts));
  endtask

  task automatic frame_abort();
    ssel_n = 1'b1;
    step(5);
    if (m_aborts < 255) m_aborts++;
    check("abort_cnt", 32'(abort_cnt), 32'(m_aborts));
    check("frame_cnt_keep", 32'(frame_cnt), 32'(m_frames % 256));
  endtask

  initial begin
    i_rst = 1'b1; ch_data = '0; ch_valid = '0; ssel_n = 1'b1; capt = 1'b0; rx_cmd = '0;
    ack_pulses = 0; exp_acks = 0;
    model_reset();
    #12;
    check("rst_buff", 32'(tx_buff), 32'hFFFF);
    check("rst_ch", 32'(tx_ch), 32'd0);
    check("rst_ack", 32'(ch_ack), 32'd0);
    check("rst_frames", 32'(frame_cnt), 32'd0);
    check("rst_aborts", 32'(abort_cnt), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(2);

    // Empty frame
    frame_open();
    frame_close(0);
    check("no_acks", 32'(ack_pulses), 32'd0);

    // Round-robin over two loaded channels
    load_word(0, 16'h1234);
    load_word(1, 16'hABCD);
    frame_open();
    check("rr_first", 32'(tx_buff), 32'h1234);
    frame_close(0);
    frame_open();
    check("rr_second", 32'(tx_buff), 32'hABCD);
    frame_close(3);

    // Forced channel 2, full then empty
    load_word(2, 16'h0F0F);
    frame_open();
    check("force_full", 32'(tx_buff), 32'h0F0F);
    frame_close(3);
    load_word(0, 16'h5555);
    frame_open();
    check("force_empty", 32'(tx_buff), 32'hFFFF);
    frame_close(0);
    frame_open();
    check("ch0_kept", 32'(tx_buff), 32'h5555);
    frame_close(0);

    // Abort restages the same word
    load_word(1, 16'h7777);
    frame_open();
    frame_abort();
    frame_open();
    check("restaged", 32'(tx_buff), 32'h7777);
    frame_close(0);

    // Reload in the consume cycle; producer activity during HOLD
    load_word(0, 16'h1111);
    frame_open();
    ch_data[0 +: DW] = 16'h2222;
    ch_valid[0] = 1'b1;
    #1;
    check("no_ack_when_full", 32'(ch_ack[0]), 32'd0);
    step();
    check("hold_stable", 32'(tx_buff), 32'h1111);
    capt = 1'b1;
    #1;
    check("ack_on_consume", 32'(ch_ack[0]), 32'd1);
    step();
    ch_valid[0] = 1'b0;
    exp_acks++;
    step();
    capt = 1'b0;
    check("xfer_stable", 32'(tx_buff), 32'h1111);
    rx_cmd = 2'd0;
    ssel_n = 1'b1;
    step(5);
    m_data[0] = 16'h2222; m_full[0] = 1'b1; m_mode = 0; m_rr = 1; m_frames++;
    check("frame_cnt_reload", 32'(frame_cnt), 32'(m_frames));
    frame_open();
    check("reloaded_word", 32'(tx_buff), 32'h2222);
    frame_close(0);

    // Asynchronous reset during XFER
    load_word(1, 16'h4321);
    frame_open();
    capt = 1'b1;
    step(2);
    capt = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_buff", 32'(tx_buff), 32'hFFFF);
    check("arst_ch", 32'(tx_ch), 32'd0);
    check("arst_frames", 32'(frame_cnt), 32'd0);
    model_reset();
    ssel_n = 1'b1;
    step(2);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(2);
    frame_open();
    check("post_rst_empty", 32'(tx_buff), 32'hFFFF);
    frame_close(0);

    // Random frames
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NC; k++)
        if (!m_full[k] && $urandom_range(0, 1) == 1) load_word(k, 16'($urandom));
      frame_open();
      if ($urandom_range(0, 4) == 0) frame_abort();
      else frame_close($urandom_range(0, 3));
    end
    step(2);
    check("ack_total", 32'(ack_pulses), 32'(exp_acks));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
